// File: rtl/debounce_pkg.sv
// Shared types and width helpers for the time-multiplexed debounce controller.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_UPDATE = 2'd2
    } state_e;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned w_of(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEF_CHANNELS = 8;
    localparam int unsigned DEF_WIDTH    = 16;
    localparam int unsigned DEF_PRESCALE = 100;

    localparam int unsigned DEF_CNT_W = w_of(DEF_WIDTH + 1);
    localparam int unsigned DEF_CH_W  = w_of(DEF_CHANNELS);
    localparam int unsigned DEF_PRE_W = w_of(DEF_PRESCALE);

endpackage

// File: rtl/debounce_prescaler.sv
// Free-running step timer with synchronous clear; tick_o fires one cycle before
// the counter wraps, so a WAIT entered from a clear lasts PRESCALE-1 cycles.
module debounce_prescaler
    import debounce_pkg::*;
#(
    parameter int unsigned PRESCALE = DEF_PRESCALE
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned PW = w_of(PRESCALE);

    logic [PW-1:0] cnt_q, cnt_d;

    always_comb begin
        if (clr_i || (cnt_q == PW'(PRESCALE - 1)))
            cnt_d = '0;
        else
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tick_o = (cnt_q == PW'(PRESCALE - 2));

endmodule

// File: rtl/debounce_scan_ctrl.sv
// Round-robin debounce engine: one shared update step walks a per-channel
// hysteresis counter array. Optional sticky change interrupt under DEBOUNCE_IRQ_EN.
module debounce_scan_ctrl
    import debounce_pkg::*;
#(
    parameter int unsigned CHANNELS = DEF_CHANNELS,
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned PRESCALE = DEF_PRESCALE
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic [CHANNELS-1:0] din_i,
    output logic [CHANNELS-1:0] dout_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o,
`ifdef DEBOUNCE_IRQ_EN
    output logic                irq_o,
    input  logic                irq_ack_i,
`endif
    output logic                scan_done_o
);

    localparam int unsigned CW  = w_of(WIDTH + 1);
    localparam int unsigned CHW = w_of(CHANNELS);

    logic [CHANNELS-1:0]         sync1_q, din_s_q;
    state_e                      state_q, state_d;
    logic                        presc_clr, tick, upd_en;
    logic [CHW-1:0]              ch_q, ch_d;
    logic [CHANNELS-1:0][CW-1:0] cnt_q, cnt_d;
    logic [CHANNELS-1:0]         dout_q, dout_d, rise_q, rise_d, fall_q, fall_d;
    logic                        done_q, done_d;
    logic                        s, lvl;
    logic [CW-1:0]               c;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            din_s_q <= '0;
        end else begin
            sync1_q <= din_i;
            din_s_q <= sync1_q;
        end
    end

    debounce_prescaler #(.PRESCALE(PRESCALE)) u_presc (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (presc_clr),
        .tick_o (tick)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // A deasserted enable is only honoured after UPDATE, so a started step always completes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (enable_i) state_d = ST_WAIT;
            ST_WAIT:   if (tick)     state_d = ST_UPDATE;
            ST_UPDATE: state_d = enable_i ? ST_WAIT : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        presc_clr = (state_q == ST_IDLE);
        upd_en    = (state_q == ST_UPDATE);
    end

    always_comb begin
        cnt_d  = cnt_q;
        dout_d = dout_q;
        rise_d = '0;
        fall_d = '0;
        done_d = 1'b0;
        ch_d   = ch_q;
        s      = din_s_q[ch_q];
        lvl    = dout_q[ch_q];
        c      = cnt_q[ch_q];
        if (upd_en) begin
            if (s == lvl) begin
                cnt_d[ch_q] = lvl ? CW'(WIDTH) : '0;
            end else if (!lvl) begin
                if (c < CW'(WIDTH)) cnt_d[ch_q] = c + 1'b1;
                else begin
                    dout_d[ch_q] = 1'b1;
                    rise_d[ch_q] = 1'b1;
                end
            end else begin
                if (c != '0) cnt_d[ch_q] = c - 1'b1;
                else begin
                    dout_d[ch_q] = 1'b0;
                    fall_d[ch_q] = 1'b1;
                end
            end
            if (ch_q == CHW'(CHANNELS - 1)) begin
                ch_d   = '0;
                done_d = 1'b1;
            end else begin
                ch_d = ch_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ch_q   <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
            done_q <= 1'b0;
        end else begin
            ch_q   <= ch_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            done_q <= done_d;
        end
    end

    assign dout_o      = dout_q;
    assign rise_o      = rise_q;
    assign fall_o      = fall_q;
    assign scan_done_o = done_q;

`ifdef DEBOUNCE_IRQ_EN
    logic irq_q, irq_d;

    // Set has priority so a change landing on the ack cycle is never lost.
    always_comb begin
        irq_d = irq_q;
        if (irq_ack_i) irq_d = 1'b0;
        if ((|rise_q) || (|fall_q)) irq_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) irq_q <= 1'b0;
        else       irq_q <= irq_d;
    end

    assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Bench for debounce_scan_ctrl (CHANNELS=4, WIDTH=3, PRESCALE=2): directed scenarios
// plus random traffic against a step-timing reference model; covers DEBOUNCE_IRQ_EN when defined.
module tb_debounce_scan_ctrl;

    localparam int CH = 4;
    localparam int W  = 3;
    localparam int P  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          irq_ack = 1'b0;
    logic [CH-1:0] din = '0;
    logic [CH-1:0] dout, rise, fall;
    logic          scan_done;
    logic          irq;

    always #5 clk = ~clk;

    debounce_scan_ctrl #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(P)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (enable),
        .din_i       (din),
        .dout_o      (dout),
        .rise_o      (rise),
        .fall_o      (fall),
`ifdef DEBOUNCE_IRQ_EN
        .irq_o       (irq),
        .irq_ack_i   (irq_ack),
`endif
        .scan_done_o (scan_done)
    );

`ifndef DEBOUNCE_IRQ_EN
    assign irq = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: engine is either parked or counting down to its next update.
    bit [CH-1:0] m_dout, m_rise, m_fall, m_s1, m_s2;
    bit          m_done, m_irq, m_busy;
    int          m_left, m_ch;
    int          m_cnt[CH];
    int          n_rise[CH], n_fall[CH], n_done;

    task automatic m_reset();
        m_dout = '0; m_rise = '0; m_fall = '0; m_s1 = '0; m_s2 = '0;
        m_done = 0; m_irq = 0; m_busy = 0; m_left = 0; m_ch = 0;
        for (int i = 0; i < CH; i++) m_cnt[i] = 0;
    endtask

    task automatic m_apply(input int i, input bit smp);
        bit l;
        l = m_dout[i];
        if (smp == l) m_cnt[i] = l ? W : 0;
        else if (!l) begin
            if (m_cnt[i] < W) m_cnt[i]++;
            else begin m_dout[i] = 1; m_rise[i] = 1; end
        end else begin
            if (m_cnt[i] > 0) m_cnt[i]--;
            else begin m_dout[i] = 0; m_fall[i] = 1; end
        end
    endtask

    // Advance the model across one rising edge using the inputs currently driven.
    task automatic m_adv();
        if (rst) begin
            m_reset();
            return;
        end
        if ((m_rise != 0) || (m_fall != 0)) m_irq = 1;
        else if (irq_ack) m_irq = 0;
        m_rise = '0; m_fall = '0; m_done = 0;
        if (!m_busy) begin
            if (enable) begin m_busy = 1; m_left = P - 1; end
        end else if (m_left > 0) begin
            m_left--;
        end else begin
            m_apply(m_ch, m_s2[m_ch]);
            if (m_ch == CH - 1) begin m_done = 1; m_ch = 0; end
            else m_ch++;
            if (enable) m_left = P - 1;
            else m_busy = 0;
        end
        m_s2 = m_s1;
        m_s1 = din;
    endtask

    task automatic clr_counts();
        n_done = 0;
        for (int i = 0; i < CH; i++) begin n_rise[i] = 0; n_fall[i] = 0; end
    endtask

    function automatic int sum_rise();
        int s = 0;
        for (int i = 0; i < CH; i++) s += n_rise[i];
        return s;
    endfunction

    function automatic int sum_fall();
        int s = 0;
        for (int i = 0; i < CH; i++) s += n_fall[i];
        return s;
    endfunction

    // One clock: model steps, then outputs are compared on the falling edge.
    task automatic cyc();
        m_adv();
        @(negedge clk);
        chk("dout", 32'(dout), 32'(m_dout));
        chk("rise", 32'(rise), 32'(m_rise));
        chk("fall", 32'(fall), 32'(m_fall));
        chk("scan_done", 32'(scan_done), 32'(m_done));
`ifdef DEBOUNCE_IRQ_EN
        chk("irq", 32'(irq), 32'(m_irq));
`endif
        chk("pulse_onehot", 32'($countones(rise | fall) <= 1), 32'd1);
        for (int i = 0; i < CH; i++) begin
            n_rise[i] += int'(rise[i]);
            n_fall[i] += int'(fall[i]);
        end
        n_done += int'(scan_done);
    endtask

    initial begin
        int k;
        m_reset();
        clr_counts();
        repeat (3) cyc();
        chk("reset_dout", 32'(dout), 32'd0);
        chk("reset_pulses", 32'({rise, fall, scan_done}), 32'd0);
        rst = 1'b0;

        // 1: reach dout=1010, reset mid-scan, stay idle until enabled
        enable = 1'b1;
        din = 4'b1010;
        repeat (60) cyc();
        chk("t1_dout_set", 32'(dout), 32'h0000000a);
        for (int t = 0; t < 20 && m_ch != 2; t++) cyc();
        chk("t1_mid_scan", 32'(m_ch), 32'd2);
        rst = 1'b1;
        #1;
        chk("t1_rst_dout", 32'(dout), 32'd0);
        chk("t1_rst_pulses", 32'({rise, fall, scan_done}), 32'd0);
        chk("t1_rst_irq", 32'(irq), 32'd0);
        enable = 1'b0;
        cyc();
        rst = 1'b0;
        clr_counts();
        repeat (8) cyc();
        chk("t1_idle_done", 32'(n_done), 32'd0);
        chk("t1_idle_dout", 32'(dout), 32'd0);

        // 2: din[1] held high
        din = 4'b0010;
        enable = 1'b1;
        clr_counts();
        repeat (80) cyc();
        chk("t2_rise1", 32'(n_rise[1]), 32'd1);
        chk("t2_nofall", 32'(sum_fall()), 32'd0);
        chk("t2_dout", 32'(dout), 32'h2);

        // 3: three-scan glitch on din[2] must not pass
        clr_counts();
        din[2] = 1'b1;
        repeat (24) cyc();
        din[2] = 1'b0;
        repeat (40) cyc();
        chk("t3_norise", 32'(sum_rise()), 32'd0);
        chk("t3_nofall", 32'(sum_fall()), 32'd0);
        chk("t3_dout", 32'(dout), 32'h2);

        // 4: set din[0], decay with a mid-decay high sample
        clr_counts();
        din[0] = 1'b1;
        for (int t = 0; t < 100 && !dout[0]; t++) cyc();
        chk("t4_set", 32'(dout[0]), 32'd1);
        din[0] = 1'b0;
        repeat (16) cyc();
        din[0] = 1'b1;
        repeat (8) cyc();
        din[0] = 1'b0;
        repeat (24) cyc();
        chk("t4_hold", 32'(dout[0]), 32'd1);
        chk("t4_nofall_yet", 32'(n_fall[0]), 32'd0);
        repeat (16) cyc();
        chk("t4_fall", 32'(n_fall[0]), 32'd1);
        chk("t4_dout", 32'(dout[0]), 32'd0);

        // 5: enable drops in WAIT at ch2
        for (int t = 0; t < 40 && !(m_busy && m_left > 0 && m_ch == 2); t++) cyc();
        chk("t5_in_wait_ch2", 32'(m_busy && m_left > 0 && m_ch == 2), 32'd1);
        enable = 1'b0;
        clr_counts();
        repeat (10) cyc();
        chk("t5_idle_done", 32'(n_done), 32'd0);
        enable = 1'b1;
        repeat (4) cyc();
        chk("t5_resume_done", 32'(n_done), 32'd1);

`ifdef DEBOUNCE_IRQ_EN
        // 6: ack coinciding with rise keeps irq; a lone ack clears it
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
        cyc();
        chk("t6_irq_cleared", 32'(irq), 32'd0);
        din[3] = 1'b1;
        for (int t = 0; t < 100 && !m_rise[3]; t++) cyc();
        chk("t6_rise3", 32'(rise[3]), 32'd1);
        irq_ack = 1'b1;
        cyc();
        chk("t6_irq_set_wins", 32'(irq), 32'd1);
        cyc();
        irq_ack = 1'b0;
        chk("t6_irq_ack", 32'(irq), 32'd0);
`endif

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                k = int'($urandom_range(0, CH - 1));
                din[k] = ~din[k];
            end
            if ($urandom_range(0, 99) == 0) enable = ~enable;
            irq_ack = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 999) == 0);
            cyc();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
